load_store_unit: RTL and testbench

- Initiator-side access unit between the MIPS pipeline's memory stage and data_memory.
- data_memory provides only a combinational word read and a whole-word synchronous write.
- This block converts CPU byte, halfword and word loads/stores into those word accesses, with lane extraction, sign/zero extension and read-modify-write for sub-word stores.
- Reports misaligned accesses as errors and never touches memory for them.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage access unit: turns byte/halfword/word loads and stores into whole-word
// accesses on a memory with a combinational read and a synchronous whole-word write.
module load_store_unit #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]           r_state;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_word;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [1:0]           r_size;
  logic                 r_write;
  logic                 r_signed;
  logic                 r_err;
  logic                 w_misaligned;
  logic                 w_word_store;

  // Little-endian lane pick; the lane is held signed so its MSB drives the extension.
  function automatic logic [WORD_SIZE-1:0] f_load_extend(
    input logic [WORD_SIZE-1:0] word,
    input logic [1:0]           off,
    input logic [1:0]           size,
    input logic                 sgn
  );
    logic signed [7:0]    lane_b;
    logic signed [15:0]   lane_h;
    logic [WORD_SIZE-1:0] res;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{(WORD_SIZE-8){sgn & lane_b[7]}}, lane_b};
      2'b01:   res = {{(WORD_SIZE-16){sgn & lane_h[15]}}, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [WORD_SIZE-1:0] f_store_merge(
    input logic [WORD_SIZE-1:0] word,
    input logic [WORD_SIZE-1:0] wdata,
    input logic [1:0]           off,
    input logic [1:0]           size
  );
    logic [WORD_SIZE-1:0] res;
    res = word;
    case (size)
      2'b00:   res[{off, 3'b000} +: 8]    = wdata[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  assign w_misaligned = (req_size == 2'b11) ||
                        ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_word_store = r_write && (r_size == 2'b10);

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_addr;

  // The write strobe is purely a function of state, so it fires exactly once per store.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_ACCESS: begin
        if (w_word_store) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = f_store_merge(r_word, r_wdata, r_addr[1:0], r_size);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_rdata  <= '0;
      r_size   <= 2'b00;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_write  <= req_write;
            r_signed <= req_signed;
            if (w_misaligned) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_write) begin
            r_rdata <= f_load_extend(mem_rdata, r_addr[1:0], r_size, r_signed);
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_word_store) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else begin
            // Sub-word store: keep the old word so the untouched lanes survive the write.
            r_word  <= mem_rdata;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a word memory and a
// shift/mask reference model of sub-word loads and stores.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, synchronous whole-word write, plus a preload port.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (word >> (int'(a[1:0]) * 8)) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (word >> (int'(a[1]) * 16)) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    if (sz == 2'd0) begin
      m = 32'hFF << (int'(a[1:0]) * 8);
      return (word & ~m) | ((d & 32'hFF) << (int'(a[1:0]) * 8));
    end else if (sz == 2'd1) begin
      m = 32'hFFFF << (int'(a[1]) * 16);
      return (word & ~m) | ((d & 32'hFFFF) << (int'(a[1]) * 16));
    end
    return d;
  endfunction

  function automatic logic ref_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 6'(idx); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issues one request and reports what came back; lat/we_lat count edges after acceptance.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int we_cnt, output int we_lat, output int acc_wait);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    acc_wait = 0;
    while (!req_ready && acc_wait < 20) begin
      @(negedge clk);
      acc_wait++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_lat = 0; rd = 32'h0BAD_0BAD; er = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_lat = i; end
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) bd_write(i, $urandom);
    bd_write(4, 32'h8765_43A1);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0)    begin errors++; $display("FAIL rst_err got %b want 0", resp_err); end
    checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0)  begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h10, 32'h10, 32'h11, 32'h12};
    logic [1:0]  sizes [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [4] = '{32'hFFFF_FFA1, 32'h0000_00A1, 32'h0000_0043, 32'hFFFF_8765};
    logic [31:0] rd; logic er; int lat, wc, wl, aw;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sizes[i], sgns[i], addrs[i], 32'hFFFF_FFFF, rd, er, lat, wc, wl, aw);
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, exps[i]); end
      checks++; if (lat != 2 || er !== 1'b0 || wc != 0) begin
        errors++; $display("FAIL load%0d_timing got lat=%0d err=%b we=%0d want 2/0/0", i, lat, er, wc); end
    end
  endtask

  task automatic test_halfword_store();
    logic [31:0] rd; logic er; int lat, wc, wl, aw;
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_BEEF, rd, er, lat, wc, wl, aw);
    ref_mem[4] = 32'hBEEF_43A1;
    checks++; if (wc != 1 || wl != 2) begin errors++; $display("FAIL sh_we got count=%0d at=%0d want 1 at 2", wc, wl); end
    checks++; if (lat != 3 || er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sh_resp got lat=%0d err=%b rd=%h want 3/0/0", lat, er, rd); end
    @(negedge clk);
    checks++; if (mem[4] !== 32'hBEEF_43A1) begin errors++; $display("FAIL sh_mem got %h want beef43a1", mem[4]); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sh_pulse got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, wc, wl, aw;
    do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, rd, er, lat, wc, wl, aw);
    ref_mem[5] = 32'hDEAD_BEEF;
    checks++; if (lat != 2 || wc != 1 || wl != 1 || er !== 1'b0) begin
      errors++; $display("FAIL sw_resp got lat=%0d we=%0d@%0d err=%b want 2 1@1 0", lat, wc, wl, er); end
    do_req(1'b0, 2'd2, 1'b1, 32'h14, 32'h0, rd, er, lat, wc, wl, aw);
    checks++; if (aw != 0) begin errors++; $display("FAIL lw_accept_wait got %0d want 0", aw); end
    checks++; if (rd !== 32'hDEAD_BEEF || lat != 2) begin
      errors++; $display("FAIL lw_rdata got %h lat=%0d want deadbeef 2", rd, lat); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h11, 32'h16, 32'h10};
    logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
    logic        wrs   [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] rd; logic er; int lat, wc, wl, aw;
    for (int i = 0; i < 3; i++) begin
      do_req(wrs[i], sizes[i], 1'b1, addrs[i], 32'h5A5A_5A5A, rd, er, lat, wc, wl, aw);
      checks++; if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || wc != 0) begin
        errors++; $display("FAIL err%0d got lat=%0d err=%b rd=%h we=%0d want 1/1/0/0", i, lat, er, rd, wc); end
      checks++; if (mem[addrs[i][7:2]] !== ref_mem[addrs[i][7:2]]) begin
        errors++; $display("FAIL err%0d_mem got %h want %h", i, mem[addrs[i][7:2]], ref_mem[addrs[i][7:2]]); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h13; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_state got rdy=%b vld=%b rd=%h want 1/0/0", req_ready, resp_valid, resp_rdata); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || mem_we) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_quiet got %0d want 0", seen); end
    checks++; if (mem[4] !== ref_mem[4]) begin errors++; $display("FAIL rmid_mem got %h want %h", mem[4], ref_mem[4]); end
  endtask

  task automatic test_busy_hold();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_addr = 32'h10;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0 || mem_addr !== 32'h14) begin
      errors++; $display("FAIL hold_first got rdy=%b addr=%h want 0 14", req_ready, mem_addr); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[5]) begin
      errors++; $display("FAIL hold_resp1 got vld=%b rd=%h want 1 %h", resp_valid, resp_rdata, ref_mem[5]); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_idle got rdy=%b vld=%b want 1 0", req_ready, resp_valid); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL hold_second got %h want 10", mem_addr); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== ref_mem[4]) begin
      errors++; $display("FAIL hold_resp2 got vld=%b rd=%h want 1 %h", resp_valid, resp_rdata, ref_mem[4]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic er, w, sg, bad; logic [1:0] sz;
    int lat, wc, wl, aw, exp_lat, bad_cnt;
    bad_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
      a = $urandom_range(0, 255); d = $urandom;
      bad = ref_bad(a, sz);
      exp_rd = 32'h0;
      if (bad) exp_lat = 1;
      else if (!w) begin exp_lat = 2; exp_rd = ref_load(ref_mem[a[7:2]], a, sz, sg); end
      else exp_lat = (sz == 2'd2) ? 2 : 3;
      do_req(w, sz, sg, a, d, rd, er, lat, wc, wl, aw);
      if (w && !bad) ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], a, sz, d);
      checks++;
      if (lat != exp_lat || er !== bad || rd !== exp_rd || wc != ((w && !bad) ? 1 : 0)) begin
        errors++; bad_cnt++;
        if (bad_cnt < 10)
          $display("FAIL rand%0d w=%b sz=%0d a=%h got lat=%0d err=%b rd=%h we=%0d want %0d/%b/%h",
                   n, w, sz, a, lat, er, rd, wc, exp_lat, bad, exp_rd);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem%0d got %h want %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    bd_we = 1'b0; bd_idx = 6'd0; bd_data = 32'h0;
    test_reset();
    test_loads();
    test_halfword_store();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_busy_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
